// File: rtl/am_frame_packer_pkg.sv
// Shared AM package: frame header default and packer state encoding.
// Contents:
//   HDR_DEFAULT   default frame header byte
//   am_state_t    3-bit state type
//   ST_*          state encodings for am_frame_packer
package am_frame_packer_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  typedef logic [2:0] am_state_t;

  localparam am_state_t ST_IDLE      = 3'd0;
  localparam am_state_t ST_CAPTURE   = 3'd1;
  localparam am_state_t ST_SEND_HDR  = 3'd2;
  localparam am_state_t ST_SEND_DATA = 3'd3;
  localparam am_state_t ST_SEND_SUM  = 3'd4;

endpackage

// File: rtl/am_frame_packer_frame_ram.sv
// Frame buffer: DEPTH x 8 simple dual-port RAM, one write port and one
// registered read port, no reset on storage or read data (block-RAM friendly).
// Ports:
//   CLK_65M   in   clock
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   write byte
//   rd_addr   in   read address (sampled every cycle)
//   rd_data   out  byte at rd_addr, one cycle later
module frame_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK_65M,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK_65M) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK_65M) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/am_frame_packer.sv
// AM frame packer: on start, captures DEPTH decimated samples into a frame
// buffer, then streams HDR, the samples in address order, and an 8-bit
// modulo-256 checksum of the samples over a valid/ready byte interface.
// Ports:
//   CLK_65M       in   system clock (rising edge)
//   RST_n         in   synchronous active-low reset
//   start         in   one-cycle frame request (honoured in IDLE only)
//   sample_in     in   8-bit sample
//   sample_valid  in   sample_in qualifier
//   tx_data       out  byte to transmitter
//   tx_valid      out  tx_data valid
//   tx_ready      in   transmitter accepts byte
//   busy          out  high whenever not IDLE
//   done          out  one-cycle pulse after checksum byte accepted
module am_frame_packer
  import am_frame_packer_pkg::*;
#(
  parameter int         DEPTH = 256,
  parameter int         DECIM = 1,
  parameter logic [7:0] HDR   = HDR_DEFAULT
) (
  input  logic       CLK_65M,
  input  logic       RST_n,
  input  logic       start,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);

  am_state_t     state;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ram_rd_addr;
  logic [7:0]    ram_rd_data;
  logic [7:0]    dec_cnt;
  logic [7:0]    sum;
  logic          xfer;
  logic          wr_en;
  logic          load;

  // Prefetch invariant: ram_rd_data always holds mem[rd_ptr], the next byte
  // to be loaded into tx_data. On a load the RAM is addressed one ahead so
  // the invariant survives back-to-back transfers.
  always_comb begin
    xfer        = tx_valid & tx_ready;
    wr_en       = (state == ST_CAPTURE) && sample_valid && (dec_cnt == '0);
    load        = xfer && ((state == ST_SEND_HDR) ||
                           ((state == ST_SEND_DATA) && (rd_ptr != '0)));
    ram_rd_addr = load ? rd_ptr + AW'(1) : rd_ptr;
    busy        = (state != ST_IDLE);
  end

  frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_frame_ram (
    .CLK_65M (CLK_65M),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sample_in),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge CLK_65M) begin
    if (!RST_n) begin
      state    <= ST_IDLE;
      wr_addr  <= '0;
      rd_ptr   <= '0;
      dec_cnt  <= '0;
      sum      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CAPTURE;
            wr_addr <= '0;
            rd_ptr  <= '0;
            dec_cnt <= '0;
            sum     <= '0;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? '0 : dec_cnt + 8'd1;
            if (dec_cnt == '0) begin
              sum     <= sum + sample_in;
              wr_addr <= wr_addr + AW'(1);
              if (wr_addr == AW'(DEPTH - 1)) begin
                state    <= ST_SEND_HDR;
                tx_data  <= HDR;
                tx_valid <= 1'b1;
              end
            end
          end
        end
        ST_SEND_HDR: begin
          if (xfer) begin
            tx_data <= ram_rd_data;
            rd_ptr  <= rd_ptr + AW'(1);
            state   <= ST_SEND_DATA;
          end
        end
        ST_SEND_DATA: begin
          // rd_ptr wraps to 0 once the last sample has been loaded.
          if (xfer) begin
            if (rd_ptr == '0) begin
              tx_data <= sum;
              state   <= ST_SEND_SUM;
            end else begin
              tx_data <= ram_rd_data;
              rd_ptr  <= rd_ptr + AW'(1);
            end
          end
        end
        ST_SEND_SUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am_frame_packer.sv
// Testbench for am_frame_packer: two instances (DECIM=1 and DECIM=2, both
// DEPTH=4) share inputs through a select; each frame is checked against a
// reference byte list built from the framing rules.
module tb_am_frame_packer;

  localparam int DEPTH = 4;

  logic       CLK_65M = 1'b0;
  logic       RST_n;
  logic       start;
  logic       sample_valid;
  logic       tx_ready;
  logic       sel;
  logic [7:0] sample_in;

  logic [7:0] a_tx_data, b_tx_data, tx_data;
  logic       a_tx_valid, b_tx_valid, tx_valid;
  logic       a_busy, b_busy, busy;
  logic       a_done, b_done, done;

  int vectors     = 0;
  int miscompares = 0;

  always #8 CLK_65M = ~CLK_65M;

  am_frame_packer #(.DEPTH(DEPTH), .DECIM(1)) u_dut_d1 (
    .CLK_65M      (CLK_65M),
    .RST_n        (RST_n),
    .start        (start & ~sel),
    .sample_in    (sample_in),
    .sample_valid (sample_valid & ~sel),
    .tx_data      (a_tx_data),
    .tx_valid     (a_tx_valid),
    .tx_ready     (tx_ready),
    .busy         (a_busy),
    .done         (a_done)
  );

  am_frame_packer #(.DEPTH(DEPTH), .DECIM(2)) u_dut_d2 (
    .CLK_65M      (CLK_65M),
    .RST_n        (RST_n),
    .start        (start & sel),
    .sample_in    (sample_in),
    .sample_valid (sample_valid & sel),
    .tx_data      (b_tx_data),
    .tx_valid     (b_tx_valid),
    .tx_ready     (tx_ready),
    .busy         (b_busy),
    .done         (b_done)
  );

  assign tx_data  = sel ? b_tx_data  : a_tx_data;
  assign tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign busy     = sel ? b_busy     : a_busy;
  assign done     = sel ? b_done     : a_done;

  // ready_mode: 0 = always ready, 1 = random, 2 = 5-cycle stall mid data.
  // abort_after > 0 returns once that many bytes have been transferred.
  task automatic run_frame(input bit use_b, input logic [7:0] samp[$],
                           input int ready_mode, input bit spam,
                           input bit gaps, input int abort_after);
    int         decim, kept, got, cycles, stall_left, stored;
    bit         stall_started, prev_v, prev_r, r, aborted;
    logic [7:0] exp_q[$];
    logic [7:0] csum, prev_d;

    decim = use_b ? 2 : 1;
    sel   = use_b;
    exp_q = {};
    exp_q.push_back(8'hA5);
    csum  = 8'h00;
    kept  = 0;
    foreach (samp[i]) begin
      if ((i % decim == 0) && (kept < DEPTH)) begin
        exp_q.push_back(samp[i]);
        csum = csum + samp[i];
        kept++;
      end
    end
    exp_q.push_back(csum);

    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge CLK_65M);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end

    foreach (samp[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          start = spam ? 1'($urandom) : 1'b0;
          @(negedge CLK_65M);
          start = 1'b0;
        end
      end
      stored = (i + decim - 1) / decim;
      if (stored < DEPTH) begin
        vectors++;
        if (tx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL capture_tx_valid: got %b expected 0 (sample %0d)", tx_valid, i);
        end
      end
      sample_valid = 1'b1;
      sample_in    = samp[i];
      start        = spam ? 1'($urandom) : 1'b0;
      @(negedge CLK_65M);
      sample_valid = 1'b0;
      start        = 1'b0;
    end

    got = 0; cycles = 0; stall_left = 0;
    stall_started = 0; prev_v = 0; prev_r = 0; prev_d = 8'h00; aborted = 0;
    while (got < exp_q.size() && cycles < 2000) begin
      if (abort_after > 0 && got == abort_after) begin
        aborted = 1;
        break;
      end
      if (prev_v && !prev_r) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
          miscompares++;
          $display("FAIL hold_while_stalled: got valid=%b data=%h expected valid=1 data=%h",
                   tx_valid, tx_data, prev_d);
        end
      end
      case (ready_mode)
        0: r = 1'b1;
        1: r = 1'($urandom);
        default: begin
          if (got == 2 && !stall_started) begin
            stall_started = 1;
            stall_left    = 5;
          end
          r = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      tx_ready = r;
      start    = spam ? 1'($urandom) : 1'b0;
      if (tx_valid === 1'b1 && r) begin
        vectors++;
        if (tx_data !== exp_q[got]) begin
          miscompares++;
          $display("FAIL frame_byte[%0d]: got %h expected %h", got, tx_data, exp_q[got]);
        end
        got++;
      end
      prev_v = (tx_valid === 1'b1);
      prev_r = r;
      prev_d = tx_data;
      @(negedge CLK_65M);
      cycles++;
    end
    start = 1'b0;

    if (!aborted) begin
      if (got < exp_q.size()) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_timeout: got %0d bytes expected %0d", got, exp_q.size());
      end else begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL frame_end: got done=%b busy=%b valid=%b expected 1 0 0",
                   done, busy, tx_valid);
        end
        if (ready_mode == 0) begin
          vectors++;
          if (cycles > 2 * exp_q.size()) begin
            miscompares++;
            $display("FAIL throughput: got %0d cycles expected <= %0d", cycles, 2 * exp_q.size());
          end
        end
        @(negedge CLK_65M);
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("FAIL done_one_cycle: got %b expected 0", done);
        end
      end
    end
  endtask

  task automatic rand_samples(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    RST_n = 1'b0; start = 1'b0; sample_valid = 1'b0; tx_ready = 1'b0;
    sample_in = 8'h00; sel = 1'b0;
    repeat (3) @(negedge CLK_65M);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got valid=%b busy=%b done=%b data=%h expected 0 0 0 00",
                 s, tx_valid, busy, done, tx_data);
      end
    end
    sel   = 1'b0;
    RST_n = 1'b1;
    @(negedge CLK_65M);
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(0, q, 0, 0, 0, 0);
  endtask

  task automatic test_decim();
    logic [7:0] q[$];
    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    run_frame(1, q, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, q, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    rand_samples(DEPTH, q);
    run_frame(0, q, 2, 0, 0, 0);
    rand_samples(2 * DEPTH, q);
    run_frame(1, q, 2, 0, 1, 0);
  endtask

  task automatic test_start_ignored();
    logic [7:0] q[$];
    rand_samples(DEPTH, q);
    run_frame(0, q, 1, 1, 1, 0);
    tx_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK_65M);
      vectors++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL extra_frame[%0d]: got valid=%b busy=%b expected 0 0", c, tx_valid, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] q[$];
    rand_samples(DEPTH, q);
    run_frame(0, q, 0, 0, 0, 3);
    RST_n    = 1'b0;
    tx_ready = 1'b0;
    @(negedge CLK_65M);
    RST_n = 1'b1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b busy=%b done=%b data=%h expected 0 0 0 00",
               tx_valid, busy, done, tx_data);
    end
    rand_samples(DEPTH, q);
    run_frame(0, q, 1, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int f = 0; f < 6; f++) begin
      bit b;
      b = 1'($urandom);
      rand_samples(b ? 2 * DEPTH : DEPTH, q);
      run_frame(b, q, (f % 2 == 0) ? 0 : 1, 0, 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_wrap();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
